spi_slave_resp: RTL and testbench
=================================

SPI_SLAVE_RESP -- requirements
Module: spi_slave_resp

Interface
REQ-001 SHALL have parameter SYNC_STG, default 2, giving the number of input synchronizer flops (2 or more).
REQ-002 SHALL have parameter ADDR_W, default 3, giving the register address width.
REQ-003 SHALL have port i_clk  in  1  system clock; all logic in this block is clocked by it.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_spi_cs  in  1  chip select from the master, active-low.
REQ-006 SHALL have port i_spi_clk  in  1  SPI clock from the master; idles high.
REQ-007 SHALL have port i_spi_mosi  in  1  serial data from the master, MSB first.
REQ-008 SHALL have port o_spi_miso  out  1  serial data to the master, MSB first.
REQ-009 SHALL have port o_addr  out  ADDR_W  register address for the current access.
REQ-010 SHALL have port o_wr_en  out  1  one-cycle register write strobe.
REQ-011 SHALL have port o_wr_data  out  8  register write data, valid while o_wr_en=1.
REQ-012 SHALL have port o_rd_en  out  1  one-cycle register read strobe.
REQ-013 SHALL have port i_rd_data  in  8  read data, sampled exactly 1 cycle after o_rd_en.
REQ-014 SHALL have port o_rx_data  out  8  last complete byte received.
REQ-015 SHALL have port o_rx_done  out  1  one-cycle pulse for every completed byte.
REQ-016 SHALL have port o_busy  out  1  high while the synchronized CS is low.

Function
REQ-017 SHALL synchronize i_spi_cs, i_spi_clk and i_spi_mosi through SYNC_STG flops each; i_spi_cs synchronizer flops reset to 1, i_spi_clk synchronizer flops reset to 1, i_spi_mosi synchronizer flops reset to 0.
REQ-018 SHALL detect SCK edges on the synchronized i_spi_clk, one cycle after the last synchronizer stage; the SCK half-period SHALL be at least 8 i_clk cycles.
REQ-019 SHALL use SPI mode 3: on a falling edge, o_spi_miso is driven from tx_shift[7] and tx_shift shifts left by 1; on a rising edge, rx_shift takes {rx_shift[6:0], mosi} and bit_cnt increments.
REQ-020 SHALL complete a byte on the 8th rising edge: o_rx_data is updated, o_rx_done pulses for 1 cycle, and bit_cnt wraps to 0.
REQ-021 SHALL implement an FSM with states IDLE, CMD, WR, RD; the synchronized CS falling edge moves IDLE to CMD.
REQ-022 SHALL decode the command byte in CMD as bit7 = R/nW and bits[ADDR_W-1:0] = address; the other bits are ignored. The address is latched into o_addr.
REQ-023 SHALL move CMD to WR when bit7=0.
REQ-024 SHALL move CMD to RD when bit7=1, pulsing o_rd_en in the cycle after the byte completes and loading i_rd_data into tx_shift on the following cycle.
REQ-025 SHALL, in WR, pulse o_wr_en with o_wr_data = the received byte in the same cycle as the byte's o_rx_done.
REQ-026 SHALL, in RD, issue the next o_rd_en/load on each byte completion so that multi-byte reads stream data.
REQ-027 SHALL drive o_spi_miso = 0 and keep tx_shift = 0 while in IDLE or CMD.
REQ-028 SHALL return to IDLE on a synchronized CS rising edge from any state, clearing bit_cnt, rx_shift and tx_shift and setting o_spi_miso to 0.
REQ-029 SHALL discard a partial byte on CS abort, with no o_rx_done, o_wr_en or o_rd_en.
REQ-030 SHALL ignore SCK edges while CS is high.
REQ-031 SHALL give CS deassertion priority when it coincides with an SCK edge in the same cycle; that edge is ignored.
REQ-032 SHALL follow REQ-024 load timing, with a latency of 5 or fewer cycles after the 8th rising edge, so the first data bit is driven on the next falling edge.

Reset
REQ-033 SHALL reset asynchronously to: state IDLE; o_spi_miso 0; o_addr 0; o_wr_en 0; o_wr_data 0; o_rd_en 0; o_rx_data 0; o_rx_done 0; o_busy 0; all shift registers and counters 0.
REQ-034 SHALL, when reset is asserted mid-frame, abort the frame with no strobes; after release it waits for a fresh CS falling edge.

Configuration
REQ-035 SHALL, when SPI_SLAVE_RESP_AUTOINC_EN is defined, increment o_addr modulo 2^ADDR_W after every data byte in WR or RD (burst access).
REQ-036 SHALL, when SPI_SLAVE_RESP_AUTOINC_EN is undefined, hold o_addr for the whole frame, so every data byte accesses the same register.

Structure
REQ-037 SHALL take the FSM state enum, CMD_RW_BIT=7 and the byte width 8 from the shared package spi_pkg.
REQ-038 SHALL place the synchronizer and edge detector in sub-module spi_sync_edge (parameter SYNC_STG; outputs: synced level, rise pulse, fall pulse), instantiated once per input.

Verification
REQ-039 SHALL verify single write: CS low, bytes 0x03 then 0xA5 -> one o_wr_en with o_addr=3 and o_wr_data=0xA5; o_rx_done pulses twice.
REQ-040 SHALL verify read: byte 0x85 with i_rd_data=0x3C -> o_rd_en with o_addr=5; MISO bits 0,0,1,1,1,1,0,0 during the next byte.
REQ-041 SHALL verify write burst: 0x06, 0x11, 0x22, 0x33 -> with AUTOINC_EN, writes to addresses 6, 7, 0; without it, three writes to address 6.
REQ-042 SHALL verify abort: CS raised after 5 bits of a data byte -> no o_wr_en; the next frame decodes correctly.
REQ-043 SHALL verify reset mid-read: i_rst_n low during a RD byte -> all outputs at reset values immediately; no stray strobes after release.
REQ-044 SHALL verify idle SCK: SCK toggling with CS high -> no o_rx_done and o_busy stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, command byte layout and the responder FSM states.
package spi_pkg;
  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } spi_state_t;

  function automatic logic cmd_is_read(input logic [BYTE_W-1:0] cmd);
    return cmd[CMD_RW_BIT];
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line, with rise/fall pulses
// derived from the synchronized level against its previous value.
module spi_sync_edge #(
  parameter int   SYNC_STG = 2,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STG-1:0] r_sync;
  logic                r_prev;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STG{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], i_d};
      r_prev <= r_sync[SYNC_STG-1];
    end
  end

  assign o_level = r_sync[SYNC_STG-1];
  assign o_rise  = r_sync[SYNC_STG-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STG-1] & r_prev;
endmodule

// File: rtl/spi_slave_resp.sv
// SPI mode-3 register-access responder: command byte (R/nW + address) then data bytes.
// Define SPI_SLAVE_RESP_AUTOINC_EN to advance the address after every data byte.
module spi_slave_resp
  import spi_pkg::*;
#(
  parameter int SYNC_STG = 2,
  parameter int ADDR_W   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_cs,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wr_en,
  output logic [BYTE_W-1:0] o_wr_data,
  output logic              o_rd_en,
  input  logic [BYTE_W-1:0] i_rd_data,
  output logic [BYTE_W-1:0] o_rx_data,
  output logic              o_rx_done,
  output logic              o_busy
);
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused_sync;

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_spi_cs),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_sck (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_spi_clk),
    .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );
  assign w_unused_sync = w_mosi_rise ^ w_mosi_fall ^ w_sck_level;

  spi_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [BYTE_W-1:0] r_rx_shift, r_tx_shift;
  logic [BYTE_W-1:0] r_rx_data, r_wr_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_miso, r_rx_done, r_wr_en, r_rd_en, r_rd_load, r_busy;

  logic              w_active, w_sck_rise_v, w_sck_fall_v, w_byte_done;
  logic [BYTE_W-1:0] w_byte;
  logic              w_cmd_done, w_wr_hit, w_rd_hit, w_tx_clear;

  // SCK edges only count inside a frame; a CS rise in the same cycle wins because the level is already high.
  assign w_active     = (r_state != IDLE) & ~w_cs_level;
  assign w_sck_rise_v = w_sck_rise & w_active;
  assign w_sck_fall_v = w_sck_fall & w_active;
  assign w_byte       = {r_rx_shift[BYTE_W-2:0], w_mosi};
  assign w_byte_done  = w_sck_rise_v & (r_bit_cnt == 3'd7);

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cs_fall) w_state_nxt = CMD;
          else           w_state_nxt = IDLE;
        end
        CMD: begin
          if (w_byte_done) w_state_nxt = cmd_is_read(w_byte) ? RD : WR;
          else             w_state_nxt = CMD;
        end
        WR:      w_state_nxt = WR;
        RD:      w_state_nxt = RD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM per-state actions for the datapath.
  always_comb begin
    w_cmd_done = 1'b0;
    w_wr_hit   = 1'b0;
    w_rd_hit   = 1'b0;
    w_tx_clear = 1'b0;
    case (r_state)
      IDLE: w_tx_clear = 1'b1;
      CMD: begin
        w_tx_clear = 1'b1;
        w_cmd_done = w_byte_done;
        w_rd_hit   = w_byte_done & cmd_is_read(w_byte);
      end
      WR:      w_wr_hit = w_byte_done;
      RD:      w_rd_hit = w_byte_done;
      default: w_tx_clear = 1'b1;
    endcase
  end

  // Shift registers, bit counter and MISO; CS rise discards any partial byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt  <= {CNT_W{1'b0}};
      r_rx_shift <= {BYTE_W{1'b0}};
      r_tx_shift <= {BYTE_W{1'b0}};
      r_miso     <= 1'b0;
    end else if (w_cs_rise) begin
      r_bit_cnt  <= {CNT_W{1'b0}};
      r_rx_shift <= {BYTE_W{1'b0}};
      r_tx_shift <= {BYTE_W{1'b0}};
      r_miso     <= 1'b0;
    end else begin
      if (w_sck_rise_v) begin
        r_rx_shift <= w_byte;
        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
      end
      if (w_tx_clear) begin
        r_tx_shift <= {BYTE_W{1'b0}};
        r_miso     <= 1'b0;
      end else if (r_rd_load) begin
        r_tx_shift <= i_rd_data;
      end else if (w_sck_fall_v) begin
        r_miso     <= r_tx_shift[BYTE_W-1];
        r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
      end
    end
  end

  // Byte-level strobes; read data is captured one cycle after the read strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_done <= 1'b0;
      r_rx_data <= {BYTE_W{1'b0}};
      r_wr_en   <= 1'b0;
      r_wr_data <= {BYTE_W{1'b0}};
      r_rd_en   <= 1'b0;
      r_rd_load <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rx_done <= w_byte_done;
      r_wr_en   <= w_wr_hit;
      r_rd_en   <= w_rd_hit;
      r_rd_load <= r_rd_en;
      r_busy    <= ~w_cs_level;
      if (w_byte_done) r_rx_data <= w_byte;
      if (w_wr_hit)    r_wr_data <= w_byte;
    end
  end

  // Register address: taken from the command byte; in burst builds it advances after each
  // data byte (after the write strobe for writes, together with the next read strobe for reads).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= {ADDR_W{1'b0}};
    end else if (w_cmd_done) begin
      r_addr <= w_byte[ADDR_W-1:0];
`ifdef SPI_SLAVE_RESP_AUTOINC_EN
    end else if (r_wr_en) begin
      r_addr <= r_addr + ADDR_W'(1);
    end else if (w_rd_hit && (r_state == RD)) begin
      r_addr <= r_addr + ADDR_W'(1);
`endif
    end else begin
      r_addr <= r_addr;
    end
  end

  assign o_spi_miso = r_miso;
  assign o_addr     = r_addr;
  assign o_wr_en    = r_wr_en;
  assign o_wr_data  = r_wr_data;
  assign o_rd_en    = r_rd_en;
  assign o_rx_data  = r_rx_data;
  assign o_rx_done  = r_rx_done;
  assign o_busy     = r_busy;
endmodule

// File: tb/tb_spi_slave_resp.sv
// Self-checking bench for spi_slave_resp: directed vector table, corner sequences, random frames.
module tb_spi_slave_resp;
  localparam int H = 10;
`ifdef SPI_SLAVE_RESP_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  typedef struct {
    logic [7:0]      cmd;
    int              nd;
    logic [3:0][7:0] din;
    int              exp_wr;
    int              exp_rd;
    logic [4:0][2:0] exp_addr;
    logic [3:0][7:0] exp_miso;
  } vec_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_spi_cs = 1'b1;
  logic       i_spi_clk = 1'b1;
  logic       i_spi_mosi = 1'b0;
  logic       o_spi_miso;
  logic [2:0] o_addr;
  logic       o_wr_en;
  logic [7:0] o_wr_data;
  logic       o_rd_en;
  logic [7:0] i_rd_data = 8'hFF;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [8];
  logic [2:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [2:0] rd_addr_q[$];
  int         rx_cnt = 0;
  logic       prev_rd_en = 1'b0;
  logic [2:0] prev_rd_addr = 3'd0;
  vec_t       tbl[7];

  spi_slave_resp #(.SYNC_STG(2), .ADDR_W(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_spi_cs(i_spi_cs), .i_spi_clk(i_spi_clk),
    .i_spi_mosi(i_spi_mosi), .o_spi_miso(o_spi_miso), .o_addr(o_addr),
    .o_wr_en(o_wr_en), .o_wr_data(o_wr_data), .o_rd_en(o_rd_en),
    .i_rd_data(i_rd_data), .o_rx_data(o_rx_data), .o_rx_done(o_rx_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Event monitor, sampled on the inactive edge.
  always @(negedge i_clk) begin
    if (o_wr_en) begin
      wr_addr_q.push_back(o_addr);
      wr_data_q.push_back(o_wr_data);
    end
    if (o_rd_en) rd_addr_q.push_back(o_addr);
    if (o_rx_done) rx_cnt = rx_cnt + 1;
  end

  // Register-file responder: read data is valid only in the cycle after o_rd_en.
  always @(posedge i_clk) begin
    #1;
    i_rd_data = prev_rd_en ? mem[prev_rd_addr] : 8'hFF;
    prev_rd_en = o_rd_en;
    prev_rd_addr = o_addr;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 0; b < nb; b++) begin
      i_spi_clk = 1'b0;
      i_spi_mosi = tx[7-b];
      cyc(H);
      rx[7-b] = o_spi_miso;
      i_spi_clk = 1'b1;
      cyc(H);
    end
  endtask

  function automatic vec_t mkv(input logic [7:0] cmd, input int nd, input logic [31:0] din,
                               input int wr, input int rd, input logic [14:0] addr,
                               input logic [31:0] miso);
    vec_t v;
    v.cmd = cmd; v.nd = nd; v.din = din; v.exp_wr = wr; v.exp_rd = rd;
    v.exp_addr = addr; v.exp_miso = miso;
    return v;
  endfunction

  // Reference model: frame-level expectations from the command byte and data count.
  function automatic vec_t model(input logic [7:0] cmd, input int nd, input logic [31:0] din);
    vec_t v;
    logic [2:0] a;
    v.cmd = cmd; v.nd = nd; v.din = din;
    v.exp_addr = '0; v.exp_miso = '0;
    for (int k = 0; k < 5; k++) begin
      a = AI ? 3'((int'(cmd[2:0]) + k) % 8) : cmd[2:0];
      v.exp_addr[k] = a;
      if (k < 4 && k < nd && cmd[7]) v.exp_miso[k] = mem[a];
    end
    v.exp_wr = cmd[7] ? 0 : nd;
    v.exp_rd = cmd[7] ? nd + 1 : 0;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int wb, rb, xb;
    logic [7:0] r;
    logic [3:0][7:0] got;
    wb = wr_addr_q.size(); rb = rd_addr_q.size(); xb = rx_cnt;
    got = '0;
    i_spi_cs = 1'b0;
    cyc(4);
    chk("busy_in_frame", {31'd0, o_busy}, 32'd1);
    spi_bits(v.cmd, 8, r);
    chk("miso_cmd_byte", {24'd0, r}, 32'd0);
    for (int k = 0; k < v.nd; k++) begin
      spi_bits(v.din[k], 8, r);
      got[k] = r;
    end
    cyc(H);
    i_spi_cs = 1'b1;
    cyc(10);
    for (int k = 0; k < v.nd; k++) chk("miso_data", {24'd0, got[k]}, {24'd0, v.exp_miso[k]});
    chk("wr_count", wr_addr_q.size() - wb, v.exp_wr);
    for (int k = 0; k < v.exp_wr && wb + k < wr_addr_q.size(); k++) begin
      chk("wr_addr", {29'd0, wr_addr_q[wb+k]}, {29'd0, v.exp_addr[k]});
      chk("wr_data", {24'd0, wr_data_q[wb+k]}, {24'd0, v.din[k]});
    end
    chk("rd_count", rd_addr_q.size() - rb, v.exp_rd);
    for (int k = 0; k < v.exp_rd && k < 5 && rb + k < rd_addr_q.size(); k++)
      chk("rd_addr", {29'd0, rd_addr_q[rb+k]}, {29'd0, v.exp_addr[k]});
    chk("rx_done_count", rx_cnt - xb, v.nd + 1);
    chk("rx_data_last", {24'd0, o_rx_data}, {24'd0, (v.nd > 0) ? v.din[v.nd-1] : v.cmd});
    chk("busy_after", {31'd0, o_busy}, 32'd0);
    chk("miso_idle", {31'd0, o_spi_miso}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, rb, xb;
    logic [7:0] r;
    mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'h42; mem[3] = 8'h63;
    mem[4] = 8'h84; mem[5] = 8'h3C; mem[6] = 8'hC6; mem[7] = 8'hE7;

    tbl[0] = mkv(8'h03, 1, 32'h000000A5, 1, 0, {3'd0, 3'd0, 3'd0, 3'd0, 3'd3}, 32'h0);
    tbl[4] = mkv(8'h07, 0, 32'h0, 0, 0, 15'd0, 32'h0);
    tbl[5] = mkv(8'h7B, 1, 32'h0000005A, 1, 0, {3'd0, 3'd0, 3'd0, 3'd0, 3'd3}, 32'h0);
`ifdef SPI_SLAVE_RESP_AUTOINC_EN
    tbl[1] = mkv(8'h85, 1, 32'h000000FF, 0, 2, {3'd0, 3'd0, 3'd0, 3'd6, 3'd5}, 32'h0000003C);
    tbl[2] = mkv(8'h06, 3, 32'h00332211, 3, 0, {3'd0, 3'd0, 3'd0, 3'd7, 3'd6}, 32'h0);
    tbl[3] = mkv(8'h82, 3, 32'h00A1B2C3, 0, 4, {3'd0, 3'd5, 3'd4, 3'd3, 3'd2}, 32'h00846342);
    tbl[6] = mkv(8'hF8, 2, 32'h00005566, 0, 3, {3'd0, 3'd0, 3'd2, 3'd1, 3'd0}, 32'h00002110);
`else
    tbl[1] = mkv(8'h85, 1, 32'h000000FF, 0, 2, {3'd0, 3'd0, 3'd0, 3'd5, 3'd5}, 32'h0000003C);
    tbl[2] = mkv(8'h06, 3, 32'h00332211, 3, 0, {3'd0, 3'd0, 3'd6, 3'd6, 3'd6}, 32'h0);
    tbl[3] = mkv(8'h82, 3, 32'h00A1B2C3, 0, 4, {3'd0, 3'd2, 3'd2, 3'd2, 3'd2}, 32'h00424242);
    tbl[6] = mkv(8'hF8, 2, 32'h00005566, 0, 3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 32'h00001010);
`endif

    // Reset state
    cyc(3);
    chk("reset_outputs", {15'd0, o_spi_miso, o_addr, o_wr_en, o_wr_data, o_rd_en, o_rx_done, o_busy},
        32'd0);
    chk("reset_rx_data", {24'd0, o_rx_data}, 32'd0);
    i_rst_n = 1'b1;
    cyc(5);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Idle SCK with CS high
    xb = rx_cnt; wb = wr_addr_q.size();
    for (int t = 0; t < 20; t++) begin
      i_spi_clk = ~i_spi_clk;
      i_spi_mosi = t[0];
      cyc(H);
      chk("idle_busy", {31'd0, o_busy}, 32'd0);
    end
    i_spi_clk = 1'b1;
    cyc(H);
    chk("idle_rx_done", rx_cnt - xb, 0);
    chk("idle_wr", wr_addr_q.size() - wb, 0);

    // Abort after 5 bits of a data byte
    xb = rx_cnt; wb = wr_addr_q.size(); rb = rd_addr_q.size();
    i_spi_cs = 1'b0;
    cyc(4);
    spi_bits(8'h04, 8, r);
    spi_bits(8'hAB, 5, r);
    i_spi_cs = 1'b1;
    cyc(12);
    chk("abort_wr", wr_addr_q.size() - wb, 0);
    chk("abort_rd", rd_addr_q.size() - rb, 0);
    chk("abort_rx_done", rx_cnt - xb, 1);
    run_vec(model(8'h01, 1, 32'h00000077));

    // Reset in the middle of a read data byte
    i_spi_cs = 1'b0;
    cyc(4);
    spi_bits(8'h85, 8, r);
    spi_bits(8'h00, 4, r);
    xb = rx_cnt; wb = wr_addr_q.size(); rb = rd_addr_q.size();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {15'd0, o_spi_miso, o_addr, o_wr_en, o_wr_data, o_rd_en, o_rx_done, o_busy},
        32'd0);
    chk("midrst_rx_data", {24'd0, o_rx_data}, 32'd0);
    i_spi_cs = 1'b1;
    i_spi_clk = 1'b1;
    cyc(5);
    i_rst_n = 1'b1;
    cyc(30);
    chk("midrst_no_wr", wr_addr_q.size() - wb, 0);
    chk("midrst_no_rd", rd_addr_q.size() - rb, 0);
    chk("midrst_no_rx", rx_cnt - xb, 0);
    run_vec(tbl[1]);

    // Random frames against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [7:0] c;
      int nd;
      c = 8'($urandom_range(0, 255));
      nd = int'($urandom_range(0, 3));
      run_vec(model(c, nd, $urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
